// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the two writeback request channels (A: ALU, B: load unit) and the
//   register-file write port owned by regfile_write_arbiter.
//
//   Signals
//     a_valid/a_rd/a_data  requester A request (driven by requester)
//     a_ready              requester A accepted this cycle (driven by arbiter)
//     b_valid/b_rd/b_data  requester B request (driven by requester)
//     b_ready              requester B accepted this cycle (driven by arbiter)
//     init_done            clear pass finished, arbitration active
//     wr_en/wr_addr/wr_data registered register-file write port
//
//   Modports
//     master : requester / register-file side (drives requests, sees results)
//     slave  : arbiter side
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              init_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  init_done, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output init_done, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Owns the single write port of the register file. After reset it walks
//   every register index once writing zero (INIT), then shares the port
//   between requester A (ALU) and requester B (load unit) with round-robin
//   arbitration over valid/ready handshakes (RUN). One registered write per
//   cycle appears on wr_en/wr_addr/wr_data, one cycle after acceptance.
//
//   Ports
//     i_clk    in  rising-edge clock
//     i_reset  in  asynchronous, active-high reset
//     bus      slave modport of regfile_write_arbiter_if
//                (request channels A/B, init_done, write port)
//
//   Parameters
//     DATA_W   write data width
//     ADDR_W   register index width
//     NUM_REGS registers cleared during INIT (<= 2**ADDR_W)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    regfile_write_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    // Register 0 is hardwired to zero, so a request targeting it completes
    // its handshake but must not pulse the write enable.
    function automatic logic rd_is_writable(input logic [ADDR_W-1:0] rd);
        return (rd != ZERO_ADDR);
    endfunction

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_last_grant_b;   // 1: B won most recently, 0: A did
    logic              r_init_done;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_run;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_xfer_a;
    logic              w_xfer_b;

    // Round-robin grant: a lone requester always wins; on a tie the side
    // that did not win last time goes first, bounding the wait to one cycle.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (bus.a_valid && bus.b_valid) begin
            if (r_last_grant_b) begin
                w_grant_a = 1'b1;
            end else begin
                w_grant_b = 1'b1;
            end
        end else if (bus.a_valid) begin
            w_grant_a = 1'b1;
        end else if (bus.b_valid) begin
            w_grant_b = 1'b1;
        end else begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
        end
    end

    // Readies are only offered once the clear pass has finished.
    always_comb begin
        w_run    = (r_state == ST_RUN);
        w_xfer_a = 1'b0;
        w_xfer_b = 1'b0;
        if (w_run) begin
            w_xfer_a = bus.a_valid & w_grant_a;
            w_xfer_b = bus.b_valid & w_grant_b;
        end else begin
            w_xfer_a = 1'b0;
            w_xfer_b = 1'b0;
        end
    end

    assign bus.a_ready   = w_run & w_grant_a;
    assign bus.b_ready   = w_run & w_grant_b;
    assign bus.init_done = r_init_done;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;

    // Sequencer: INIT clear pass, then registered capture of granted writes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_INIT;
            r_cnt          <= ZERO_ADDR;
            r_last_grant_b <= 1'b1;
            r_init_done    <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= ZERO_ADDR;
            r_wr_data      <= ZERO_DATA;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_cnt;
                    r_wr_data <= ZERO_DATA;
                    // The counter stops at the last index; it is never reused
                    // in RUN, so it simply stays saturated there.
                    if (r_cnt == LAST_IDX) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE_ADDR;
                    end
                end
                ST_RUN: begin
                    if (w_xfer_a) begin
                        r_wr_en        <= rd_is_writable(bus.a_rd);
                        r_wr_addr      <= bus.a_rd;
                        r_wr_data      <= bus.a_data;
                        r_last_grant_b <= 1'b0;
                    end else if (w_xfer_b) begin
                        r_wr_en        <= rd_is_writable(bus.b_rd);
                        r_wr_addr      <= bus.b_rd;
                        r_wr_data      <= bus.b_data;
                        r_last_grant_b <= 1'b1;
                    end else begin
                        // Idle cycle: address/data hold, only the enable drops.
                        r_wr_en <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh clear pass.
                    r_state        <= ST_INIT;
                    r_cnt          <= ZERO_ADDR;
                    r_last_grant_b <= 1'b1;
                    r_init_done    <= 1'b0;
                    r_wr_en        <= 1'b0;
                    r_wr_addr      <= ZERO_ADDR;
                    r_wr_data      <= ZERO_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Randomized bench with a behavioural reference model and an expected-write
//   scoreboard. The driver issues requests, predicts readies and the resulting
//   register-file writes; a separate monitor pops and compares every write the
//   DUT presents. Model and DUT register-file images are compared at the end.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                edges  = 0;     // rising edges since reset release
    bit                last_b = 1'b1;  // B counts as the most recent winner after reset
    wr_t               exp_q[$];
    logic [DATA_W-1:0] model_regs [NUM_REGS];
    logic [DATA_W-1:0] dut_regs   [NUM_REGS];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && bus.wr_en === 1'b1) begin
            wr_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write at %0t",
                         bus.wr_addr, bus.wr_data, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {{(DATA_W-ADDR_W){1'b0}}, bus.wr_addr},
                      {{(DATA_W-ADDR_W){1'b0}}, e.addr});
                check("wr_data", bus.wr_data, e.data);
            end
            dut_regs[bus.wr_addr] = bus.wr_data;
        end
    end

    // One cycle: drive inputs, predict and check readies, queue expected write.
    task automatic drive_cycle(input bit av, input logic [ADDR_W-1:0] ard,
                               input logic [DATA_W-1:0] ad,
                               input bit bv, input logic [ADDR_W-1:0] brd,
                               input logic [DATA_W-1:0] bd,
                               output bit acc_a, output bit acc_b);
        bit run;
        bit ga;
        bit gb;
        @(negedge clk);
        bus.a_valid = av;  bus.a_rd = ard;  bus.a_data = ad;
        bus.b_valid = bv;  bus.b_rd = brd;  bus.b_data = bd;
        #1;
        run = (edges >= NUM_REGS);
        ga  = 1'b0;
        gb  = 1'b0;
        if (run) begin
            if (av && bv) begin
                ga = last_b;
                gb = !last_b;
            end else begin
                ga = av;
                gb = bv;
            end
        end
        check("a_ready",   {63'd0, bus.a_ready},   {63'd0, ga});
        check("b_ready",   {63'd0, bus.b_ready},   {63'd0, gb});
        check("init_done", {63'd0, bus.init_done}, {63'd0, run});
        if (!run) begin
            exp_q.push_back('{ADDR_W'(edges), {DATA_W{1'b0}}});
            model_regs[edges] = {DATA_W{1'b0}};
        end else if (ga || gb) begin
            logic [ADDR_W-1:0] rd;
            logic [DATA_W-1:0] d;
            rd     = ga ? ard : brd;
            d      = ga ? ad  : bd;
            last_b = gb;
            if (rd != {ADDR_W{1'b0}}) begin
                exp_q.push_back('{rd, d});
                model_regs[rd] = d;
            end
        end
        acc_a = ga;
        acc_b = gb;
        @(posedge clk);
        edges++;
    endtask

    task automatic idle(input int n);
        bit xa, xb;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, xa, xb);
    endtask

    function automatic logic [ADDR_W-1:0] pick_rd();
        case ($urandom_range(0, 3))
            0:       return {ADDR_W{1'b0}};
            1:       return ADDR_W'($urandom_range(1, 3));
            default: return ADDR_W'($urandom_range(0, NUM_REGS - 1));
        endcase
    endfunction

    task automatic random_phase(input int n);
        bit pa = 1'b0, pb = 1'b0, xa, xb;
        logic [ADDR_W-1:0] ra = '0, rb = '0;
        logic [DATA_W-1:0] da = '0, db = '0;
        for (int i = 0; i < n; i++) begin
            if (!pa && $urandom_range(0, 99) < 60) begin
                pa = 1'b1; ra = pick_rd(); da = {$urandom, $urandom};
            end else if (pa && $urandom_range(0, 99) < 4) begin
                pa = 1'b0;   // withdrawn request
            end
            if (!pb && $urandom_range(0, 99) < 60) begin
                pb = 1'b1; rb = pick_rd(); db = {$urandom, $urandom};
            end else if (pb && $urandom_range(0, 99) < 4) begin
                pb = 1'b0;
            end
            drive_cycle(pa, ra, da, pb, rb, db, xa, xb);
            if (xa) pa = 1'b0;
            if (xb) pb = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},     {63'd0, bus.wr_en},     64'd0);
        check({tag, "_wr_addr"},   {59'd0, bus.wr_addr},   64'd0);
        check({tag, "_wr_data"},   bus.wr_data,            64'd0);
        check({tag, "_init_done"}, {63'd0, bus.init_done}, 64'd0);
        check({tag, "_a_ready"},   {63'd0, bus.a_ready},   64'd0);
        check({tag, "_b_ready"},   {63'd0, bus.b_ready},   64'd0);
    endtask

    // Assert reset between edges; any in-flight write is dropped.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        edges  = 0;
        last_b = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit xa, xb;
        bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            model_regs[i] = {DATA_W{1'b1}};
            dut_regs[i]   = {DATA_W{1'b0}};
        end
        bus.a_valid = 1'b1;   // readies must stay low while in reset
        bus.b_valid = 1'b1;
        #12;
        check_reset_outputs("reset");
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Clear pass with requests pending: they must wait.
        for (int i = 0; i < NUM_REGS; i++)
            drive_cycle(1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'hAA, xa, xb);

        // Single A request, then idle.
        drive_cycle(1'b1, 5'd5, 64'h1234, 1'b0, '0, '0, xa, xb);
        idle(2);

        // Both continuously valid: alternating grants.
        for (int i = 0; i < 6; i++)
            drive_cycle(1'b1, 5'd1, 64'hA1, 1'b1, 5'd2, 64'hB2, xa, xb);

        // rd==0 from B completes with no write, then a tie goes to A.
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 64'hFF, xa, xb);
        drive_cycle(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, xa, xb);
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd4, 64'h44, xa, xb);

        // Same destination from both: later write must win.
        drive_cycle(1'b1, 5'd7, 64'h700, 1'b1, 5'd7, 64'h701, xa, xb);
        drive_cycle(1'b0, '0, '0, 1'b1, 5'd7, 64'h701, xa, xb);
        idle(1);

        random_phase(1500);

        // Reset during a RUN transfer.
        drive_cycle(1'b1, 5'd12, 64'hDEAD, 1'b0, '0, '0, xa, xb);
        apply_reset("run_reset");
        idle(10);
        // Reset in the middle of the clear pass.
        apply_reset("init_reset");
        idle(NUM_REGS);

        random_phase(1500);
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes actual=%0d required=0", exp_q.size());
        end
        for (int i = 0; i < NUM_REGS; i++)
            check($sformatf("regfile[%0d]", i), dut_regs[i], model_regs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
